// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture path.
// The saturation value is the same full-scale duty code the PWM generators use.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } cap_state_e;

    localparam int         DUTY_W   = 8;
    localparam int         DIV_LAT  = 10;
    localparam logic [7:0] DUTY_SAT = 8'hFF;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing the 8-bit duty code from {H, 8'b0} / P.
// One load cycle followed by 9 quotient-bit cycles; a quotient of 256 saturates.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W+7:0]    num,
    input  logic [CNT_W-1:0]    den,
    output logic                busy,
    output logic                done,
    output logic [DUTY_W-1:0]   quot
);

    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] den_q;
    logic [7:0]       lo;
    logic [8:0]       q;
    logic [3:0]       step;
    logic             ge;

    // Step 0 tests the integer part (H >= P) before any fraction bit is shifted in.
    always_comb begin
        trial = (step == 4'd0) ? rem : {rem[CNT_W-1:0], lo[7]};
        ge    = (trial >= {1'b0, den_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            den_q <= '0;
            lo    <= '0;
            q     <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                rem   <= {1'b0, num[CNT_W+7:8]};
                lo    <= num[7:0];
                den_q <= den;
                q     <= '0;
                step  <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                rem <= ge ? (trial - {1'b0, den_q}) : trial;
                q   <= {q[7:0], ge};
                if (step != 4'd0) begin
                    lo <= {lo[6:0], 1'b0};
                end
                if (step == 4'(DIV_LAT - 2)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                step <= step + 4'd1;
            end
        end
    end

    assign quot = q[8] ? DUTY_SAT : q[7:0];

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes pwm_in, counts period and high time between rising
// edges, and publishes period/high_time/duty with a one-cycle valid strobe.
//
// state   | meaning
// IDLE    | disabled; counters cleared, divider aborted, outputs held
// ARM     | waiting for the first rising edge to start counting
// MEASURE | counting; each rising edge captures and starts a divide
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    output logic [CNT_W-1:0]    period,
    output logic [CNT_W-1:0]    high_time,
    output logic [DUTY_W-1:0]   duty,
    output logic                valid,
    output logic                stuck,
    output logic                ovr
);

    cap_state_e        state;
    logic [1:0]        sync_q;
    logic              s;
    logic              s_d;
    logic              rise;
    logic [CNT_W-1:0]  cnt_per;
    logic [CNT_W-1:0]  cnt_hi;
    logic [CNT_W-1:0]  p_cap;
    logic [CNT_W-1:0]  h_cap;
    logic              timeout_hit;
    logic              div_start;
    logic              div_abort;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quot;

    assign s    = sync_q[1];
    assign rise = s & ~s_d;

    // A rise in the same cycle as the timeout wins, so the timeout is gated by ~rise.
    assign timeout_hit = en && (state == MEASURE) && !rise && (cnt_per == CNT_W'(TIMEOUT));
    assign div_start   = en && (state == MEASURE) && rise && !div_busy;
    assign div_abort   = !en || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_per   <= '0;
            cnt_hi    <= '0;
            p_cap     <= '0;
            h_cap     <= '0;
            period    <= '0;
            high_time <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            valid <= 1'b0;
            ovr   <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt_per <= '0;
                cnt_hi  <= '0;
            end else begin
                if (div_done) begin
                    period    <= p_cap;
                    high_time <= h_cap;
                    duty      <= div_quot;
                    stuck     <= 1'b0;
                    valid     <= 1'b1;
                end
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            cnt_per <= CNT_W'(1);
                            cnt_hi  <= CNT_W'(1);
                            state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            cnt_per <= CNT_W'(1);
                            cnt_hi  <= CNT_W'(1);
                            if (div_busy) begin
                                ovr <= 1'b1;
                            end else begin
                                p_cap <= cnt_per;
                                h_cap <= cnt_hi;
                            end
                        end else if (timeout_hit) begin
                            stuck     <= 1'b1;
                            period    <= '0;
                            high_time <= '0;
                            duty      <= s ? DUTY_SAT : '0;
                            valid     <= 1'b1;
                            cnt_per   <= '0;
                            cnt_hi    <= '0;
                            state     <= ARM;
                        end else begin
                            cnt_per <= cnt_per + CNT_W'(1);
                            cnt_hi  <= cnt_hi + CNT_W'(s);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (div_abort),
        .num   ({cnt_hi, 8'b0}),
        .den   (cnt_per),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives known PWM waveforms and compares each
// published result against hand-computed period, high time and duty values.
module tb_pwm_capture;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 1000;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              pwm_in;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic [7:0]        duty;
    logic              valid;
    logic              stuck;
    logic              ovr;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;

    logic [31:0] q_per[$];
    logic [31:0] q_hi[$];
    logic [31:0] q_duty[$];
    logic [31:0] q_stuck[$];

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .duty      (duty),
        .valid     (valid),
        .stuck     (stuck),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            q_per.push_back(period);
            q_hi.push_back(high_time);
            q_duty.push_back(32'(duty));
            q_stuck.push_back(32'(stuck));
        end
        if (ovr) ovr_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_per.delete();
        q_hi.delete();
        q_duty.delete();
        q_stuck.delete();
        ovr_cnt = 0;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (h) @(negedge clk);
            pwm_in = 1'b0;
            repeat (p - h) @(negedge clk);
        end
    endtask

    task automatic restart_en();
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        clear_log();
    endtask

    // Every logged result must match one (period, high, duty) triple.
    task automatic check_results(input string tag, input int n, input int p, input int h, input int d);
        check_val({tag, "_count"}, 32'(q_per.size()), 32'(n));
        for (int i = 0; i < q_per.size(); i++) begin
            check_val({tag, "_period"}, q_per[i], 32'(p));
            check_val({tag, "_high"}, q_hi[i], 32'(h));
            check_val({tag, "_duty"}, q_duty[i], 32'(d));
            check_val({tag, "_stuck"}, q_stuck[i], 32'd0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_period", period, 32'd0);
        check_val("rst_high", high_time, 32'd0);
        check_val("rst_duty", 32'(duty), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_stuck", 32'(stuck), 32'd0);
        check_val("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        en = 1'b1;
        clear_log();
        wave(100, 25, 5);
        repeat (20) @(negedge clk);
        check_results("d25", 4, 100, 25, 64);
        check_val("d25_ovr", 32'(ovr_cnt), 32'd0);

        restart_en();
        wave(100, 99, 3);
        repeat (20) @(negedge clk);
        check_results("d99", 2, 100, 99, 253);

        restart_en();
        wave(256, 1, 3);
        repeat (20) @(negedge clk);
        check_results("p256", 2, 256, 1, 1);

        // Static input: last full period is captured, then the timeout reports stuck high.
        restart_en();
        wave(100, 50, 2);
        pwm_in = 1'b1;
        repeat (1200) @(negedge clk);
        check_val("st_count", 32'(q_per.size()), 32'd3);
        if (q_per.size() == 3) begin
            check_val("st_pre_period", q_per[1], 32'd100);
            check_val("st_period", q_per[2], 32'd0);
            check_val("st_high", q_hi[2], 32'd0);
            check_val("st_duty", q_duty[2], 32'd255);
            check_val("st_flag", q_stuck[2], 32'd1);
        end
        check_val("st_level", 32'(stuck), 32'd1);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        clear_log();
        wave(100, 50, 3);
        repeat (20) @(negedge clk);
        check_results("st_restart", 2, 100, 50, 128);
        check_val("st_cleared", 32'(stuck), 32'd0);

        // P=6 alternates accepted captures with dropped ones.
        restart_en();
        wave(6, 3, 20);
        repeat (20) @(negedge clk);
        check_results("short", 10, 6, 3, 128);
        check_val("short_ovr", 32'(ovr_cnt), 32'd9);

        // Enable drop while a divide is in flight.
        restart_en();
        wave(100, 40, 2);
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (36) @(negedge clk);
        pwm_in = 1'b0;
        repeat (60) @(negedge clk);
        wave(100, 40, 2);
        check_results("en_pre", 1, 100, 40, 102);
        clear_log();
        en = 1'b1;
        wave(200, 50, 1);
        check_val("en_first_edge", 32'(q_per.size()), 32'd0);
        check_val("en_hold_period", period, 32'd100);
        check_val("en_hold_duty", 32'(duty), 32'd102);
        wave(200, 50, 1);
        check_results("en_after", 1, 200, 50, 64);

        // Asynchronous reset during a divide.
        restart_en();
        wave(100, 50, 2);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_period", period, 32'd0);
        check_val("ar_high", high_time, 32'd0);
        check_val("ar_duty", 32'(duty), 32'd0);
        check_val("ar_valid", 32'(valid), 32'd0);
        repeat (45) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (45) @(negedge clk);
        wave(100, 50, 1);
        check_val("ar_first_edge", 32'(q_per.size()), 32'd0);
        wave(100, 50, 1);
        check_results("ar_after", 1, 100, 50, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
